// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM model with a programmable access latency behind the
// memory_control RAM-side handshake.
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_ni       asynchronous active-low reset
//   ram_ren_i    read request, held by the initiator until ACCESS
//   ram_wen_i    write request, held by the initiator until ACCESS
//   ram_addr_i   byte address; word index is ram_addr_i[ADDR_BITS+1:2]
//   ram_store_i  write data, sampled in the ACCESS cycle
//   ram_load_o   read data, valid in a read's ACCESS cycle and held otherwise
//   ram_state_o  FREE / BUSY / ACCESS / ERROR
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LAT       = 2
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      ram_ren_i,
    input  logic      ram_wen_i,
    input  word_t     ram_addr_i,
    input  word_t     ram_store_i,
    output word_t     ram_load_o,
    output ramstate_t ram_state_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_START = 4'(LAT > 1 ? LAT - 2 : 0);

    state_t                 state_q, state_d;
    logic                   wr_q, wr_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [3:0]             cnt_q, cnt_d;
    word_t                  load_q;
    word_t                  mem_q [2**ADDR_BITS];

    logic                   req, bad, match, start, commit;
    logic [ADDR_BITS-1:0]   idx;

    assign idx    = ram_addr_i[ADDR_BITS+1:2];
    assign req    = (ram_ren_i ^ ram_wen_i) && ram_addr_i[1:0] == 2'b00 &&
                    ram_addr_i[31:ADDR_BITS+2] == '0;
    // Junk on the address lines with no request asserted is not an error.
    assign bad    = (ram_ren_i || ram_wen_i) && !req;
    assign match  = req && ram_wen_i == wr_q && idx == idx_q;
    // A valid request that differs from the latched one while waiting restarts the
    // count in place, so every request reaches ACCESS LAT cycles after it first appears.
    assign start  = req && (state_q == IDLE || (state_q == WAIT && !match));
    assign commit = state_q == DONE && wr_q && match;

    always_comb begin
        state_d     = IDLE;
        wr_d        = wr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ram_state_o = bad ? ERROR :
                      state_q == DONE ? ACCESS :
                      (state_q == WAIT || req) ? BUSY : FREE;
        if (start) begin
            wr_d    = ram_wen_i;
            idx_d   = idx;
            cnt_d   = CNT_START;
            state_d = LAT == 1 ? DONE : WAIT;
        end else if (state_q == WAIT && match) begin
            state_d = cnt_q == 4'd0 ? DONE : WAIT;
            cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= 4'd0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            // DONE always falls back to IDLE, so state_d == DONE only on the entering edge.
            if (state_d == DONE && !wr_d)
                load_q <= mem_q[idx_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (commit)
            mem_q[idx_q] <= ram_store_i;
    end

    assign ram_load_o = load_q;
endmodule
